// File: rtl/sequence_generator_serial_tx.sv
// Serial bit-pattern transmitter.
// Accepts a parallel pattern and a repeat count over a valid/ready handshake, then shifts the
// pattern out one bit per clock, repeating it repeat_cnt times with GAP idle cycles between
// repetitions. A one-cycle done pulse marks completion.
// Optional build macro: SEQGEN_LSB_FIRST_EN -- when defined, bits are sent LSB first instead of
// MSB first. Timing, handshake and counts are the same in both builds.
module sequence_generator_serial_tx #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned GapW = (GAP > 0) ? (($clog2(GAP + 1) > 0) ? $clog2(GAP + 1) : 1) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(PAT_W - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit GapEn = (GAP > 0);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;   // bits still to go, head bit is next on x
  logic [PAT_W-1:0] pat_q, pat_d;       // captured copy used to reload each repetition
  logic [BitW-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Advance the shift register by one bit in the configured direction.
  function automatic logic [PAT_W-1:0] shift_pat(input logic [PAT_W-1:0] v);
`ifdef SEQGEN_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  // Bit that appears on x when the shift register holds v.
  function automatic logic head_bit(input logic [PAT_W-1:0] v);
`ifdef SEQGEN_LSB_FIRST_EN
    return v[0];
`else
    return v[PAT_W-1];
`endif
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;

    case (state_q)
      StIdle: begin
        if (start_valid) begin
          pat_d   = pattern;
          shreg_d = pattern;
          rep_d   = repeat_cnt;
          bit_d   = BitLast;
          state_d = (repeat_cnt == '0) ? StDone : StSend;
        end
      end
      StSend: begin
        if (bit_q != '0) begin
          shreg_d = shift_pat(shreg_q);
          bit_d   = bit_q - BitW'(1);
        end else begin
          // Last bit of this repetition is on x now.
          rep_d = rep_q - CNT_W'(1);
          if (rep_q <= CNT_W'(1)) begin
            state_d = StDone;
          end else if (GapEn) begin
            gap_d   = GapLoad;
            state_d = StGap;
          end else begin
            // Back-to-back: reload so the next repetition follows with no bubble.
            shreg_d = pat_q;
            bit_d   = BitLast;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          shreg_d = pat_q;
          bit_d   = BitLast;
          state_d = StSend;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered, so decode them from the state being entered.
    x_valid_d = (state_d == StSend);
    x_d       = (state_d == StSend) ? head_bit(shreg_d) : 1'b0;
    busy_d    = (state_d == StSend) || (state_d == StGap);
    done_d    = (state_d == StDone);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      pat_q     <= '0;
      bit_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      bit_q     <= bit_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Ready is decoded straight from state so an accept can happen in any IDLE cycle.
  always_comb begin
    start_ready = (state_q == StIdle);
    x           = x_q;
    x_valid     = x_valid_q;
    busy        = busy_q;
    done        = done_q;
  end

endmodule

// File: doc/sequence_generator_serial_tx.md
Name: sequence_generator_serial_tx

Overview:
Serial bit-pattern transmitter that pairs with the team's serial sequence detectors.
- Accepts a parallel pattern and a repeat count through a valid/ready handshake.
- Shifts the pattern out one bit per clock on a serial line, with an optional idle gap between repetitions.
- Drives detector inputs directly, in test harnesses and in stimulus paths.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of repeat count
GAP, 1, idle cycles inserted between consecutive repetitions (0 = back-to-back)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start_valid  input  1  request to transmit
start_ready  output  1  block can accept a request
pattern  input  PAT_W  pattern to send, sampled on handshake
repeat_cnt  input  CNT_W  number of repetitions, sampled on handshake
x  output  1  serial data bit
x_valid  output  1  x carries a pattern bit this cycle
busy  output  1  transmission in progress
done  output  1  one-cycle pulse when a request completes

Behaviour:
- Reset values: state=IDLE, x=0, x_valid=0, busy=0, done=0, start_ready=1, shift register=0, counters=0.
- Reset takes effect immediately and asynchronously, including mid-transmission. The remaining bits are discarded and no done pulse is generated.
- All outputs are registered, except start_ready, which is decoded from state (1 only in IDLE).
- Handshake: a request is accepted on the rising edge where start_valid=1 and start_ready=1. start_valid while not IDLE is ignored; no queueing.
- On accept:
  - pattern is captured into the shift register; repeat_cnt into the rep counter; bit counter is set to PAT_W-1.
  - If repeat_cnt==0: next state DONE, no bits emitted.
  - Otherwise: next state SEND.
- Latency: first bit is on x with x_valid=1 in the cycle after the accepting edge.
- States:
  - IDLE: x=0, x_valid=0, busy=0.
  - SEND:
    - x = MSB of the shift register, x_valid=1, busy=1.
    - Each cycle shift left by 1 and decrement the bit counter.
    - When the last bit (bit counter 0) is presented, decrement the rep counter.
    - If reps remain and GAP>0: -> GAP.
    - If reps remain and GAP=0: reload the captured pattern and stay in SEND. The next bit follows with no bubble.
    - If none remain: -> DONE.
  - GAP:
    - x=0, x_valid=0, busy=1 for exactly GAP cycles (gap counter).
    - Then reload the pattern, reset the bit counter, -> SEND.
  - DONE: done=1 for exactly one cycle, busy=0, x_valid=0, -> IDLE. start_ready is 0 in DONE, so the earliest new accept is the cycle after done.
- A captured pattern copy is held unchanged for the request duration. Changes on the pattern input after accept have no effect.
- Bits per request = PAT_W × repeat_cnt. Total cycles from accept to done = PAT_W×repeat_cnt + GAP×(repeat_cnt−1) + 1.
- Counter widths: bit counter clog2(PAT_W), gap counter clog2(GAP+1) (minimum 1), rep counter CNT_W. No wrap: the maximum repeat_cnt = 2^CNT_W−1 is sent in full.
- Illegal state encodings return to IDLE.

Optional Feature:
SEQGEN_LSB_FIRST_EN
- Defined: the shift register shifts right and x = LSB, so the pattern is sent LSB first.
- Undefined (default): MSB first as above.
- Timing, handshake and counts are identical in both builds.

Test Plan:
1. Reset, then pattern=4'b1011, repeat_cnt=1, start_valid pulse.
   - x sequence 1,0,1,1 with x_valid=1 for 4 cycles starting the cycle after accept.
   - done=1 on the 5th cycle, start_ready=1 on the 6th.
2. pattern=4'b1011, repeat_cnt=2, GAP=0.
   - x=1,0,1,1,1,0,1,1 with x_valid continuous for 8 cycles, then done.
   - Fed into a 1011 detector, the detector asserts exactly twice.
3. pattern=4'b1100, repeat_cnt=3, GAP=2.
   - Stream 1100, two cycles x_valid=0, 1100, two gap cycles, 1100, then done.
   - 17 cycles from accept to done.
4. repeat_cnt=0: accept, x_valid never asserts, done pulses the cycle after accept.
5. Hold start_valid=1 and change pattern during SEND (repeat_cnt=2, GAP=0, different pattern on the input).
   - start_ready stays 0 and the transmitted bits are unaffected.
   - A new request is accepted only after done; it is not taken during DONE.
6. Assert rst during the second bit of a request.
   - x_valid, busy and x go to 0 immediately, with no done pulse and start_ready=1.
   - A fresh request afterwards transmits correctly.
   - Repeat case 1 with SEQGEN_LSB_FIRST_EN defined: x = 1,1,0,1.
